// File: rtl/multi_shift_reg_seq.sv
// multi_shift_reg_seq: WIDTH-bit register that runs one multi-cycle shift
// command per start request. It shifts one bit position per clock in the
// selected mode and reports progress on busy/done/err.
module multi_shift_reg_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] M_PLOAD = 3'b000;
   localparam logic [2:0] M_SLL   = 3'b001;
   localparam logic [2:0] M_SRL   = 3'b010;
   localparam logic [2:0] M_ROL   = 3'b011;
   localparam logic [2:0] M_ROR   = 3'b100;
   localparam logic [2:0] M_SRA   = 3'b101;

   // Shift counts above the register width are clamped to this value
   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ser_q, ser_d;
   logic [2:0]       mode_q, mode_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] shift_val;
   logic             shift_out;

   // One-bit shift of the current register under the latched mode
   always_comb begin
      shift_val = data_q;
      shift_out = 1'b0;
      case (mode_q)
         M_SLL: begin
            shift_val = {data_q[WIDTH-2:0], ser_in};
            shift_out = data_q[WIDTH-1];
         end
         M_SRL: begin
            shift_val = {ser_in, data_q[WIDTH-1:1]};
            shift_out = data_q[0];
         end
         M_ROL: begin
            shift_val = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            shift_out = data_q[WIDTH-1];
         end
         M_ROR: begin
            shift_val = {data_q[0], data_q[WIDTH-1:1]};
            shift_out = data_q[0];
         end
         M_SRA: begin
            shift_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            shift_out = data_q[0];
         end
         default: begin
            shift_val = data_q;
            shift_out = 1'b0;
         end
      endcase
   end

   // Next-state logic: command acceptance in IDLE, stepping in SHIFT
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ser_d   = ser_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (mode > M_SRA) begin
                  err_d = 1'b1;
               end else if (mode == M_PLOAD) begin
                  data_d  = load_data;
                  state_d = S_DONE;
               end else if (count == '0) begin
                  state_d = S_DONE;
               end else begin
                  mode_d  = mode;
                  rem_d   = (count > WIDTH_C) ? WIDTH_C : count;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            data_d = shift_val;
            ser_d  = shift_out;
            rem_d  = rem_q - ONE_C;
            if (rem_q == ONE_C) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with asynchronous clear of all control and data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         ser_q   <= 1'b0;
         mode_q  <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ser_q   <= ser_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   assign q       = data_q;
   assign ser_out = ser_q;
   assign busy    = (state_q == S_SHIFT);
   assign done    = (state_q == S_DONE);
   assign err     = err_q;

endmodule

// File: tb/tb_multi_shift_reg_seq.sv
// Directed bench for multi_shift_reg_seq: per-cycle vector table plus
// hand-written reset sequences.
module tb_multi_shift_reg_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] mode;
   logic [3:0] count;
   logic [7:0] load_data;
   logic       ser_in;
   logic [7:0] q;
   logic       ser_out;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic       st;
      logic [2:0] md;
      logic [3:0] cnt;
      logic [7:0] ld;
      logic       si;
      logic [7:0] eq;
      logic       es;
      logic       eb;
      logic       ed;
      logic       ee;
   } vec_t;

   vec_t tbl[$];

   multi_shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .count     (count),
      .load_data (load_data),
      .ser_in    (ser_in),
      .q         (q),
      .ser_out   (ser_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s [step %0d]: got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic add(input logic st, input logic [2:0] md, input logic [3:0] cnt,
                      input logic [7:0] ld, input logic si, input logic [7:0] eq,
                      input logic es, input logic eb, input logic ed, input logic ee);
      vec_t v;
      v.st = st; v.md = md; v.cnt = cnt; v.ld = ld; v.si = si;
      v.eq = eq; v.es = es; v.eb = eb; v.ed = ed; v.ee = ee;
      tbl.push_back(v);
   endtask

   task automatic check_all(input int idx, input logic [7:0] eq, input logic es,
                            input logic eb, input logic ed, input logic ee);
      check("q", idx, 32'(q), 32'(eq));
      check("ser_out", idx, 32'(ser_out), 32'(es));
      check("busy", idx, 32'(busy), 32'(eb));
      check("done", idx, 32'(done), 32'(ed));
      check("err", idx, 32'(err), 32'(ee));
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst = 1'b1;
      start = 1'b0;
      mode = 3'b000;
      count = 4'd0;
      load_data = 8'h00;
      ser_in = 1'b0;

      //   st md  cnt  ld     si  q      so bsy dn err
      // PLOAD 0xA5
      add(1, 0, 4'd0, 8'hA5, 0, 8'hA5, 0, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'hA5, 0, 0, 0, 0);
      // SLL x3 with ser_in=1; mode/count changed after E0
      add(1, 1, 4'd3, 8'h00, 1, 8'hA5, 0, 1, 0, 0);
      add(0, 7, 4'd0, 8'hFF, 1, 8'h4B, 1, 1, 0, 0);
      add(0, 7, 4'd0, 8'hFF, 1, 8'h97, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 1, 8'h2F, 1, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h2F, 1, 0, 0, 0);
      // PLOAD 0x85, then SRA x2 with start held during SHIFT/DONE
      add(1, 0, 4'd0, 8'h85, 0, 8'h85, 1, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h85, 1, 0, 0, 0);
      add(1, 5, 4'd2, 8'h00, 0, 8'h85, 1, 1, 0, 0);
      add(1, 0, 4'd0, 8'hFF, 0, 8'hC2, 1, 1, 0, 0);
      add(1, 0, 4'd0, 8'hFF, 0, 8'hE1, 0, 0, 1, 0);
      add(1, 0, 4'd0, 8'hFF, 0, 8'hE1, 0, 0, 0, 0);
      // SRL x1 with ser_in=0
      add(1, 2, 4'd1, 8'h00, 0, 8'hE1, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h70, 1, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h70, 1, 0, 0, 0);
      // PLOAD 0x3C, ROR x8
      add(1, 0, 4'd0, 8'h3C, 0, 8'h3C, 1, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 1, 0, 0, 0);
      add(1, 4, 4'd8, 8'h00, 0, 8'h3C, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h1E, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h0F, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h87, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'hC3, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'hE1, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'hF0, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h78, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 0, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 0, 0, 0, 0);
      // ROL with count=12 clamps to 8
      add(1, 3, 4'd12, 8'h00, 0, 8'h3C, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h78, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'hF0, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'hE1, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'hC3, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h87, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h0F, 1, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h1E, 0, 1, 0, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 0, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 0, 0, 0, 0);
      // invalid modes 110 and 111
      add(1, 6, 4'd3, 8'hFF, 0, 8'h3C, 0, 0, 0, 1);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 0, 0, 0, 0);
      add(1, 7, 4'd1, 8'hFF, 0, 8'h3C, 0, 0, 0, 1);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 0, 0, 0, 0);
      // SLL with count=0
      add(1, 1, 4'd0, 8'hFF, 1, 8'h3C, 0, 0, 1, 0);
      add(0, 0, 4'd0, 8'h00, 0, 8'h3C, 0, 0, 0, 0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all(-1, 8'h00, 0, 0, 0, 0);
      rst = 1'b0;

      // table-driven cycles
      for (int i = 0; i < tbl.size(); i++) begin
         start     = tbl[i].st;
         mode      = tbl[i].md;
         count     = tbl[i].cnt;
         load_data = tbl[i].ld;
         ser_in    = tbl[i].si;
         @(posedge clk);
         #1;
         check_all(i, tbl[i].eq, tbl[i].es, tbl[i].eb, tbl[i].ed, tbl[i].ee);
      end

      // asynchronous reset in the middle of a SHIFT command
      start = 1'b1; mode = 3'b001; count = 4'd5; ser_in = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check_all(100, 8'h79, 0, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all(101, 8'h00, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all(102, 8'h00, 0, 0, 0, 0);
      rst = 1'b0;

      // PLOAD works after the reset
      start = 1'b1; mode = 3'b000; load_data = 8'h5A;
      @(posedge clk);
      #1;
      check_all(103, 8'h5A, 0, 0, 1, 0);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_all(104, 8'h5A, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_shift_reg_seq.md
Name: multi_shift_reg_seq

Overview:
Parametrised, sequential successor to the 5-way shift-mode selector.
- Holds a WIDTH-bit register.
- Executes one multi-cycle shift command per start request: one bit position per clock, repeated `count` times, in the selected mode.
- Reports progress with busy/done/err.
- Sits between a command source (controller or testbench) and downstream logic that consumes the parallel `q` and the serial `ser_out`.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the `count` port; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command request; sampled only in IDLE.
- mode  input  3  000 PLOAD, 001 SLL, 010 SRL, 011 ROL, 100 ROR, 101 SRA, 110/111 invalid.
- count  input  CNT_W  number of single-bit shifts; ignored for PLOAD.
- load_data  input  WIDTH  parallel load value for PLOAD.
- ser_in  input  1  serial fill bit for SLL/SRL; sampled on every shift edge.
- q  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted out (registered).
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; `q` is final in that same cycle.
- err  output  1  one-cycle pulse on an invalid mode.

Behaviour:
- Reset (asynchronous, any time, including mid-command): state=IDLE; q, ser_out, busy, done, err all 0; latched mode/remaining count cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=0: hold everything.
- IDLE, start=1 (edge E0):
  - mode invalid: err=1 for one cycle; stay in IDLE; q and ser_out unchanged; no done.
  - PLOAD: q<=load_data at E0; go to DONE.
  - shift mode, count==0: go to DONE; q unchanged.
  - shift mode, count>=1: latch mode; remaining = min(count, WIDTH); go to SHIFT; q unchanged at E0.
- SHIFT: each edge performs one shift on q, sets ser_out = bit shifted out, and decrements remaining. The edge that takes remaining to 0 moves the FSM to DONE.
  - SLL: q <= {q[W-2:0], ser_in}; out = q[W-1].
  - SRL: q <= {ser_in, q[W-1:1]}; out = q[0].
  - ROL: q <= {q[W-2:0], q[W-1]}; out = q[W-1].
  - ROR: q <= {q[0], q[W-1:1]}; out = q[0].
  - SRA: q <= {q[W-1], q[W-1:1]}; out = q[0].
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: start at E0 with N shifts gives busy high for N cycles after E0 and done high in cycle N+1. PLOAD and count=0 give done in the cycle after E0.
- Count saturates at WIDTH (e.g. WIDTH=8, count=12 -> 8 shifts).
- start while in SHIFT or DONE is ignored; it is not queued.
- mode, count, load_data may change after E0 without effect on the command in flight. ser_in is live.
- ser_out changes only on shift edges; PLOAD and count=0 leave it unchanged.
- busy and done are never high together. err is never high together with busy or done.

Test Plan:
- After reset, PLOAD load_data=0xA5 -> q=0xA5 one edge later; done pulses 1 cycle; busy stays 0; ser_out=0.
- q=0xA5, SLL count=3, ser_in=1 -> q steps 0x4B, 0x97, 0x2F; busy for exactly 3 cycles; done next cycle; ser_out=1.
- q=0x85, SRA count=2 -> q steps 0xC2, 0xE1; ser_out=0. Then SRL count=1 with ser_in=0 -> q=0x70, ser_out=1.
- q=0x3C, ROR count=8 -> q returns to 0x3C after 8 busy cycles. ROL count=12 -> clamps to 8 busy cycles; q=0x3C.
- mode=110 with start -> err 1-cycle pulse; q unchanged; no busy, no done. count=0 SLL -> done the next cycle; q unchanged.
- start re-asserted during busy is ignored: command completes normally. rst asserted mid-SHIFT -> q=0, busy=0 immediately (asynchronous); a new PLOAD afterwards works.
